// File: rtl/serq_rx.sv
// Serial-to-parallel receiver feeding a DEPTH-entry circular word queue.
// Optional SERQ_RX_DROP_CNT_EN adds a saturating dropped-word counter port.
module serq_rx #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 8,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int AFULL_LEVEL = DEPTH - 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         data_in,
  input  logic                         write_in,
  output logic                         status_out,
  output logic                         afull_out,
  input  logic                         dequeue_in,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic [$clog2(DEPTH+1)-1:0]   len_out,
  output logic                         overflow_out
`ifdef SERQ_RX_DROP_CNT_EN
  ,
  output logic [7:0]                   drop_cnt_out
`endif
);

  // state   | meaning
  // IDLE    | no partial word, waiting for first bit strobe
  // COLLECT | partial word in the shift register
  // PUSH    | one cycle: enqueue the completed word or drop it
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int BW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_PUSH} state_t;

  state_t                r_state, w_state_next;
  logic                  r_write_q, r_deq_q;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [BW-1:0]         r_bit_cnt, w_bit_cnt_next;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_head, r_tail, w_head_next, w_tail_next;
  logic [CW-1:0]         r_count, w_count_next;
  logic [DATA_WIDTH-1:0] r_data_out, w_data_next;
  logic                  r_status, r_afull, r_overflow;
  logic                  w_wr_rise, w_deq_rise, w_capture, w_push, w_pop, w_drop;

  function automatic logic [PW-1:0] f_wrap(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_wr_rise  = write_in & ~r_write_q;
  assign w_deq_rise = dequeue_in & ~r_deq_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_bit_cnt <= w_bit_cnt_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_bit_cnt_next = r_bit_cnt;
    w_capture      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_wr_rise) begin
          w_capture      = 1'b1;
          w_bit_cnt_next = BW'(1);
          w_state_next   = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (w_wr_rise) begin
          w_capture      = 1'b1;
          w_bit_cnt_next = r_bit_cnt + 1'b1;
          if (r_bit_cnt == BW'(DATA_WIDTH - 1)) w_state_next = S_PUSH;
        end
      end
      S_PUSH: begin
        w_bit_cnt_next = '0;
        w_state_next   = S_IDLE;
      end
      default: begin
        w_bit_cnt_next = '0;
        w_state_next   = S_IDLE;
      end
    endcase
  end

  // A pop in the PUSH cycle frees the slot, so a full queue still accepts the word.
  always_comb begin
    w_pop        = w_deq_rise && (r_count != '0);
    w_push       = (r_state == S_PUSH) && ((r_count != CW'(DEPTH)) || w_pop);
    w_drop       = (r_state == S_PUSH) && !w_push;
    w_head_next  = w_pop ? f_wrap(r_head) : r_head;
    w_tail_next  = w_push ? f_wrap(r_tail) : r_tail;
    w_count_next = r_count + CW'(w_push) - CW'(w_pop);
    w_data_next  = '0;
    if (w_count_next != '0) begin
      if (w_push && (w_head_next == r_tail)) w_data_next = r_shift;
      else                                   w_data_next = r_mem[w_head_next];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_write_q  <= 1'b0;
      r_deq_q    <= 1'b0;
      r_shift    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_data_out <= '0;
      r_status   <= 1'b0;
      r_afull    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_write_q  <= write_in;
      r_deq_q    <= dequeue_in;
      if (w_capture) begin
        if (MSB_FIRST) r_shift <= {r_shift[DATA_WIDTH-2:0], data_in};
        else           r_shift <= {data_in, r_shift[DATA_WIDTH-1:1]};
      end
      r_head     <= w_head_next;
      r_tail     <= w_tail_next;
      r_count    <= w_count_next;
      r_data_out <= w_data_next;
      r_status   <= (w_count_next < CW'(DEPTH));
      r_afull    <= (w_count_next >= CW'(AFULL_LEVEL));
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_tail] <= r_shift;
  end

`ifdef SERQ_RX_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clock) begin
    if (reset)                              r_drop_cnt <= '0;
    else if (w_drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 1'b1;
  end

  assign drop_cnt_out = r_drop_cnt;
`endif

  assign status_out   = r_status;
  assign afull_out    = r_afull;
  assign data_out     = r_data_out;
  assign len_out      = r_count;
  assign overflow_out = r_overflow;

endmodule

// File: tb/tb_serq_rx.sv
// Scoreboard bench for serq_rx: MSB-first instance plus an LSB-first instance.
// Each output change is popped against a queue of hand-computed expected snapshots.
module tb_serq_rx;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset = 1'b1, data_in = 1'b0, write_in = 1'b0, dequeue_in = 1'b0;
  logic       status_out, afull_out, overflow_out;
  logic [7:0] data_out;
  logic [3:0] len_out;

  logic       l_reset = 1'b1, l_data = 1'b0, l_write = 1'b0, l_deq = 1'b0;
  logic       l_status, l_afull, l_overflow;
  logic [7:0] l_dout;
  logic [3:0] l_len;

`ifdef SERQ_RX_DROP_CNT_EN
  logic [7:0] drop_cnt_out, l_drop_cnt;
`endif

  serq_rx #(.DATA_WIDTH(8), .DEPTH(8), .MSB_FIRST(1'b1), .AFULL_LEVEL(7)) u_dut (
    .clock(clock), .reset(reset), .data_in(data_in), .write_in(write_in),
    .status_out(status_out), .afull_out(afull_out), .dequeue_in(dequeue_in),
    .data_out(data_out), .len_out(len_out), .overflow_out(overflow_out)
`ifdef SERQ_RX_DROP_CNT_EN
    , .drop_cnt_out(drop_cnt_out)
`endif
  );

  serq_rx #(.DATA_WIDTH(8), .DEPTH(8), .MSB_FIRST(1'b0), .AFULL_LEVEL(7)) u_dut_lsb (
    .clock(clock), .reset(l_reset), .data_in(l_data), .write_in(l_write),
    .status_out(l_status), .afull_out(l_afull), .dequeue_in(l_deq),
    .data_out(l_dout), .len_out(l_len), .overflow_out(l_overflow)
`ifdef SERQ_RX_DROP_CNT_EN
    , .drop_cnt_out(l_drop_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [14:0] exp_q[$];
  logic [14:0] lexp_q[$];
  logic [14:0] prev_m, prev_l, cur_m, cur_l;

  // Snapshot layout: {overflow, status, afull, len[3:0], data[7:0]}
  assign cur_m = {overflow_out, status_out, afull_out, len_out, data_out};
  assign cur_l = {l_overflow, l_status, l_afull, l_len, l_dout};

  function automatic logic [14:0] snap(input logic ovf, input logic st, input logic af,
                                       input logic [3:0] len, input logic [7:0] d);
    return {ovf, st, af, len, d};
  endfunction

  always @(posedge clock) begin
    logic [14:0] e;
    #1;
    if (!reset && cur_m !== prev_m) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL msb_unexpected: got %h, expected no output change", cur_m);
      end else begin
        e = exp_q.pop_front();
        if (cur_m !== e) begin
          n_fail++;
          $display("FAIL msb_snapshot: got %h, expected %h", cur_m, e);
        end
      end
    end
    prev_m = cur_m;
  end

  always @(posedge clock) begin
    logic [14:0] e;
    #1;
    if (!l_reset && cur_l !== prev_l) begin
      n_tests++;
      if (lexp_q.size() == 0) begin
        n_fail++;
        $display("FAIL lsb_unexpected: got %h, expected no output change", cur_l);
      end else begin
        e = lexp_q.pop_front();
        if (cur_l !== e) begin
          n_fail++;
          $display("FAIL lsb_snapshot: got %h, expected %h", cur_l, e);
        end
      end
    end
    prev_l = cur_l;
  end

  task automatic send_bit(input bit sel, input logic b, input bit pop_sync);
    @(negedge clock);
    if (sel) begin l_data = b; l_write = 1'b1; end
    else     begin data_in = b; write_in = 1'b1; end
    if (pop_sync) begin
      @(negedge clock);
      dequeue_in = 1'b1;
      repeat (9) @(negedge clock);
    end else begin
      repeat (10) @(negedge clock);
    end
    if (sel) l_write = 1'b0;
    else     write_in = 1'b0;
    if (pop_sync) dequeue_in = 1'b0;
    repeat (9) @(negedge clock);
  endtask

  // Bits go out in argument order from bit 7 down to bit 0.
  task automatic send_word(input bit sel, input logic [7:0] w, input bit pop_sync);
    for (int i = 7; i >= 0; i--) send_bit(sel, w[i], pop_sync && (i == 0));
  endtask

  task automatic pop(input bit sel);
    @(negedge clock);
    if (sel) l_deq = 1'b1; else dequeue_in = 1'b1;
    repeat (5) @(negedge clock);
    if (sel) l_deq = 1'b0; else dequeue_in = 1'b0;
    repeat (5) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    exp_q.push_back(snap(1'b0, 1'b1, 1'b0, 4'd0, 8'h00));
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic fill_eight();
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(snap(1'b0, k < 7, (k + 1) >= 7, 4'(k + 1), 8'h80));
      send_word(1'b0, 8'h80 + 8'(k), 1'b0);
    end
  endtask

  initial begin
    logic [3:0] len;
    repeat (3) @(negedge clock);
    do_reset();

    fill_eight();
    exp_q.push_back(snap(1'b1, 1'b0, 1'b1, 4'd8, 8'h80));
    send_word(1'b0, 8'h88, 1'b0);
`ifdef SERQ_RX_DROP_CNT_EN
    n_tests++;
    if (drop_cnt_out !== 8'd1) begin
      n_fail++;
      $display("FAIL drop_cnt: got %0d, expected 1", drop_cnt_out);
    end
`endif
    for (int i = 0; i < 8; i++) begin
      len = 4'(7 - i);
      exp_q.push_back(snap(1'b1, 1'b1, len >= 7, len, (i < 7) ? 8'h81 + 8'(i) : 8'h00));
      pop(1'b0);
    end

    do_reset();
    fill_eight();
    exp_q.push_back(snap(1'b0, 1'b0, 1'b1, 4'd8, 8'h81));
    send_word(1'b0, 8'h88, 1'b1);
    for (int i = 0; i < 8; i++) begin
      len = 4'(7 - i);
      exp_q.push_back(snap(1'b0, 1'b1, len >= 7, len, (i < 7) ? 8'h82 + 8'(i) : 8'h00));
      pop(1'b0);
    end

    for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b1, 1'b0);
    do_reset();
    exp_q.push_back(snap(1'b0, 1'b1, 1'b0, 4'd1, 8'hA5));
    send_word(1'b0, 8'hA5, 1'b0);
    exp_q.push_back(snap(1'b0, 1'b1, 1'b0, 4'd0, 8'h00));
    pop(1'b0);
    pop(1'b0);
    n_tests++;
    if (len_out !== 4'd0 || data_out !== 8'h00) begin
      n_fail++;
      $display("FAIL empty_pop: got len %0d data %h, expected len 0 data 00", len_out, data_out);
    end
    exp_q.push_back(snap(1'b0, 1'b1, 1'b0, 4'd1, 8'h3C));
    send_word(1'b0, 8'h3C, 1'b0);

    lexp_q.push_back(snap(1'b0, 1'b1, 1'b0, 4'd0, 8'h00));
    l_reset = 1'b0;
    repeat (2) @(negedge clock);
    lexp_q.push_back(snap(1'b0, 1'b1, 1'b0, 4'd1, 8'h01));
    send_word(1'b1, 8'h80, 1'b0);
    lexp_q.push_back(snap(1'b0, 1'b1, 1'b0, 4'd2, 8'h01));
    send_word(1'b1, 8'h40, 1'b0);
    lexp_q.push_back(snap(1'b0, 1'b1, 1'b0, 4'd1, 8'h02));
    @(negedge clock);
    l_deq = 1'b1;
    repeat (200) @(negedge clock);
    l_deq = 1'b0;
    repeat (5) @(negedge clock);
    n_tests++;
    if (l_len !== 4'd1) begin
      n_fail++;
      $display("FAIL held_dequeue: got len %0d, expected 1", l_len);
    end

    repeat (10) @(negedge clock);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL msb_drain: got %0d pending events, expected 0", exp_q.size());
    end
    n_tests++;
    if (lexp_q.size() != 0) begin
      n_fail++;
      $display("FAIL lsb_drain: got %0d pending events, expected 0", lexp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
